// File: rtl/machine_timer_if.sv
// Bus between the machine timer and its host: count/load controls and compare value in,
// counter value, tick pulse and interrupt request out.
interface machine_timer_if;
  logic        en;
  logic        load;
  logic [31:0] data_in;
  logic [31:0] mtimecmp;
  logic        cmp_load;
  logic [31:0] mtime;
  logic        tick;
  logic        timer_irq;

  // Host side: drives controls and compare value, observes counter and interrupt.
  modport master (
    output en, load, data_in, mtimecmp, cmp_load,
    input  mtime, tick, timer_irq
  );

  // Timer side.
  modport slave (
    input  en, load, data_in, mtimecmp, cmp_load,
    output mtime, tick, timer_irq
  );
endinterface

// File: rtl/machine_timer.sv
// Machine-mode timer: free-running 32-bit mtime with prescaler, software loadable,
// compared every cycle against mtimecmp to produce a registered level interrupt.
// Handshake: no valid/ready; load and cmp_load are single-cycle strobes sampled on
// the rising edge, and every output is a flop (no input-to-output combinational path).
module machine_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic           clk,
  input  logic           rst,
  machine_timer_if.slave bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic [31:0]   mtime_q, mtime_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          irq_q, irq_d;

  // Next-state for counter, prescaler, tick; load wins over counting.
  always_comb begin
    mtime_d = mtime_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (bus.load) begin
      mtime_d = bus.data_in;
      presc_d = '0;
    end else if (bus.en) begin
      if (presc_q == PRESC_LAST) begin
        mtime_d = mtime_q + 32'd1;
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  // Interrupt compares the registered count; all-ones compare disables it and a
  // compare write masks it for one cycle so the new value is seen first.
  always_comb begin
    irq_d = (bus.mtimecmp != 32'hFFFF_FFFF) && (mtime_q >= bus.mtimecmp) && !bus.cmp_load;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q <= '0;
      presc_q <= '0;
      tick_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      irq_q   <= irq_d;
    end
  end

  assign bus.mtime     = mtime_q;
  assign bus.tick      = tick_q;
  assign bus.timer_irq = irq_q;

endmodule

// File: tb/tb_machine_timer.sv
// Bench for machine_timer: two instances (PRESCALE 4 and 1) share one stimulus stream
// and are checked against a cycle-level behavioural model, plus directed scenarios.
module tb_machine_timer;

  localparam int unsigned P0 = 4;
  localparam int unsigned P1 = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en;
  logic        load;
  logic [31:0] data_in;
  logic [31:0] mtimecmp;
  logic        cmp_load;

  machine_timer_if if0 ();
  machine_timer_if if1 ();

  assign if0.en = en;  assign if0.load = load;  assign if0.data_in = data_in;
  assign if0.mtimecmp = mtimecmp;  assign if0.cmp_load = cmp_load;
  assign if1.en = en;  assign if1.load = load;  assign if1.data_in = data_in;
  assign if1.mtimecmp = mtimecmp;  assign if1.cmp_load = cmp_load;

  machine_timer #(.PRESCALE(P0)) u0 (.clk(clk), .rst(rst), .bus(if0.slave));
  machine_timer #(.PRESCALE(P1)) u1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Counts enabled cycles since the last load/reset/increment; after PRESCALE of them
  // the counter advances. Interrupt is the comparison result one cycle late.
  longint unsigned m_mtime [2];
  int              m_cnt   [2];
  bit              m_tick  [2];
  bit              m_irq   [2];
  int              m_pre   [2];

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_mtime[i] = 0; m_cnt[i] = 0; m_tick[i] = 0; m_irq[i] = 0;
      end else begin
        m_irq[i]  = (mtimecmp != 32'hFFFF_FFFF) && (m_mtime[i] >= mtimecmp) && !cmp_load;
        m_tick[i] = 0;
        if (load) begin
          m_mtime[i] = data_in;
          m_cnt[i]   = 0;
        end else if (en) begin
          m_cnt[i]++;
          if (m_cnt[i] == m_pre[i]) begin
            m_mtime[i] = (m_mtime[i] + 1) % 64'h1_0000_0000;
            m_cnt[i]   = 0;
            m_tick[i]  = 1;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(m_mtime[i][31:0]);
      exp_q.push_back({31'd0, m_tick[i]});
      exp_q.push_back({31'd0, m_irq[i]});
    end
    chk("u0.mtime", if0.mtime, exp_q.pop_front());
    chk("u0.tick",  {31'd0, if0.tick}, exp_q.pop_front());
    chk("u0.irq",   {31'd0, if0.timer_irq}, exp_q.pop_front());
    chk("u1.mtime", if1.mtime, exp_q.pop_front());
    chk("u1.tick",  {31'd0, if1.tick}, exp_q.pop_front());
    chk("u1.irq",   {31'd0, if1.timer_irq}, exp_q.pop_front());
  endtask

  // ---------------- driver ----------------
  // One clock: inputs already set; advance model at the edge, compare 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle();
    rst = 0; en = 0; load = 0; data_in = 0; cmp_load = 0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1;
    for (int i = 0; i < cycles; i++) step();
    rst = 0;
  endtask

  int ticks;

  initial begin
    m_pre[0] = P0; m_pre[1] = P1;
    for (int i = 0; i < 2; i++) begin
      m_mtime[i] = 0; m_cnt[i] = 0; m_tick[i] = 0; m_irq[i] = 0;
    end
    idle();
    mtimecmp = 32'hFFFF_FFFF;

    // 1. reset dominates en and load
    en = 1; load = 1; data_in = 32'h1234_5678;
    do_reset(2);
    chk("rst.mtime", if0.mtime, 32'd0);
    chk("rst.tick",  {31'd0, if0.tick}, 32'd0);
    chk("rst.irq",   {31'd0, if0.timer_irq}, 32'd0);
    idle();

    // 2. PRESCALE=4 counting from zero
    en = 1; ticks = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (if0.tick) ticks++;
      if (c == 4)  chk("p4.mtime@4", if0.mtime, 32'd1);
      if (c == 4)  chk("p4.tick@4", {31'd0, if0.tick}, 32'd1);
      if (c == 3)  chk("p4.tick@3", {31'd0, if0.tick}, 32'd0);
    end
    chk("p4.mtime@20", if0.mtime, 32'd5);
    chk("p4.ticks", ticks, 32'd5);
    chk("p1.mtime@20", if1.mtime, 32'd20);

    // 3. PRESCALE=1 with mtimecmp=10
    idle(); mtimecmp = 32'd10;
    do_reset(1);
    en = 1;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 10) chk("p1.irq@eq", {31'd0, if1.timer_irq}, 32'd0);
      if (c >= 11) chk("p1.irq@ge", {31'd0, if1.timer_irq}, 32'd1);
    end

    // 4. wrap through all-ones
    idle(); mtimecmp = 32'hFFFF_FFF0;
    load = 1; data_in = 32'hFFFF_FFFE; step();
    chk("wrap.load", if1.mtime, 32'hFFFF_FFFE);
    load = 0; en = 1;
    step(); chk("wrap.ff", if1.mtime, 32'hFFFF_FFFF);
    chk("wrap.irq_ff", {31'd0, if1.timer_irq}, 32'd1);
    step(); chk("wrap.zero", if1.mtime, 32'd0);
    chk("wrap.tick", {31'd0, if1.tick}, 32'd1);
    chk("wrap.irq_hold", {31'd0, if1.timer_irq}, 32'd1);
    step(); chk("wrap.irq_fall", {31'd0, if1.timer_irq}, 32'd0);

    // 5. disabled compare, then rewrite
    idle(); mtimecmp = 32'hFFFF_FFFF;
    load = 1; data_in = 32'd100; step();
    load = 0;
    for (int c = 0; c < 3; c++) begin
      step(); chk("dis.irq", {31'd0, if1.timer_irq}, 32'd0);
    end
    mtimecmp = 32'd50; cmp_load = 1; step();
    chk("cmpw.irq0", {31'd0, if1.timer_irq}, 32'd0);
    cmp_load = 0; step();
    chk("cmpw.irq1", {31'd0, if1.timer_irq}, 32'd1);

    // 6. load at prescaler terminal count, then reset mid-count
    idle(); do_reset(1);
    en = 1;
    for (int c = 0; c < 3; c++) step();
    load = 1; data_in = 32'd7; step();
    chk("sim.mtime", if0.mtime, 32'd7);
    chk("sim.tick", {31'd0, if0.tick}, 32'd0);
    load = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      if (c == 3) chk("sim.phase3", if0.mtime, 32'd7);
      if (c == 4) chk("sim.phase4", if0.mtime, 32'd8);
    end
    mtimecmp = 32'd2; step();
    rst = 1; step(); rst = 0;
    chk("midrst.mtime", if0.mtime, 32'd0);
    chk("midrst.irq", {31'd0, if1.timer_irq}, 32'd0);

    // Random phase: model checks every cycle
    idle();
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 199) == 0);
      en       = ($urandom_range(0, 9) < 7);
      load     = ($urandom_range(0, 39) == 0);
      data_in  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15)
                                             : $urandom_range(0, 300);
      cmp_load = ($urandom_range(0, 19) == 0);
      if (cmp_load) begin
        case ($urandom_range(0, 3))
          0:       mtimecmp = 32'hFFFF_FFFF;
          1:       mtimecmp = $urandom;
          default: mtimecmp = $urandom_range(0, 300);
        endcase
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
